// File: rtl/vm_pkg.sv
// vm_pkg: shared state encoding, coin constants and one-hot coin select type
// for the change dispenser.
package vm_pkg;

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, FINISH} state_t;

    localparam int COIN_5 = 5;
    localparam int COIN_2 = 2;
    localparam int COIN_1 = 1;

    // One-hot coin choice: bit 2 = 5 rupee, bit 1 = 2 rupee, bit 0 = 1 rupee.
    typedef logic [2:0] coin_sel_t;

    localparam coin_sel_t SEL_NONE = 3'b000;
    localparam coin_sel_t SEL_1    = 3'b001;
    localparam coin_sel_t SEL_2    = 3'b010;
    localparam coin_sel_t SEL_5    = 3'b100;

    function automatic int coin_value(coin_sel_t s);
        return s[2] ? COIN_5 : s[1] ? COIN_2 : s[0] ? COIN_1 : 0;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time through the
// coin hopper, greedily choosing 5/2/1 rupee coins and skipping empty tubes.
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   change_valid/_amt     change request in; change_ready accepts it (IDLE only)
//   empty_5/_2/_1         hopper tube empty flags, sampled when choosing a coin
//   hopper_ready          hopper takes the pending eject on this edge
//   eject_5/_2/_1         one-hot eject request, held until hopper_ready
//   busy                  payout in progress
//   done, short_err       one-cycle completion pulse and shortfall flag
//   remaining             rupees still owed (unpaid amount after a shortfall)
module change_dispenser #(
    parameter int AMT_W     = 7,
    parameter int EJECT_GAP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             change_valid,
    input  logic [AMT_W-1:0] change_amt,
    output logic             change_ready,
    input  logic             empty_5,
    input  logic             empty_2,
    input  logic             empty_1,
    input  logic             hopper_ready,
    output logic             eject_5,
    output logic             eject_2,
    output logic             eject_1,
    output logic             busy,
    output logic             done,
    output logic             short_err,
    output logic [AMT_W-1:0] remaining
);
    import vm_pkg::*;

    // Last count value of the settle gap; unused when EJECT_GAP is 0.
    localparam logic [3:0] GAP_LAST = 4'(EJECT_GAP - 1);

    state_t           state_q, state_d;
    coin_sel_t        sel_q, sel_d, pick;
    logic [AMT_W-1:0] remaining_q, remaining_d, rem_left;
    logic             err_q, err_d;
    logic [3:0]       gap_q, gap_d;

    // Greedy choice: largest coin that fits the amount and has stock.
    assign pick = (remaining_q >= AMT_W'(COIN_5) && !empty_5) ? SEL_5 :
                  (remaining_q >= AMT_W'(COIN_2) && !empty_2) ? SEL_2 :
                  (remaining_q >= AMT_W'(COIN_1) && !empty_1) ? SEL_1 : SEL_NONE;

    assign rem_left = remaining_q - AMT_W'(coin_value(sel_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= SEL_NONE;
            remaining_q <= '0;
            err_q       <= 1'b0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        remaining_d = remaining_q;
        err_d       = err_q;
        gap_d       = gap_q;
        case (state_q)
            IDLE: begin
                if (change_valid) begin
                    remaining_d = change_amt;
                    state_d     = (change_amt == '0) ? FINISH : SELECT;
                end
            end
            SELECT: begin
                sel_d   = pick;
                err_d   = (pick == SEL_NONE);
                state_d = (pick == SEL_NONE) ? FINISH : EJECT;
            end
            EJECT: begin
                if (hopper_ready) begin
                    remaining_d = rem_left;
                    gap_d       = '0;
                    state_d     = (rem_left == '0) ? FINISH :
                                  (EJECT_GAP > 0)  ? GAP : SELECT;
                end
            end
            GAP: begin
                gap_d   = gap_q + 4'd1;
                state_d = (gap_q == GAP_LAST) ? SELECT : GAP;
            end
            FINISH: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state only, so they are glitch-free.
    always_comb begin
        change_ready = (state_q == IDLE);
        busy         = (state_q != IDLE);
        done         = (state_q == FINISH);
        short_err    = (state_q == FINISH) && err_q;
        eject_5      = (state_q == EJECT) && sel_q[2];
        eject_2      = (state_q == EJECT) && sel_q[1];
        eject_1      = (state_q == EJECT) && sel_q[0];
        remaining    = remaining_q;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench; stimulus pushes expected ejects and
// completions, a monitor pops and compares them as the DUT produces them.
module tb_change_dispenser;

    localparam int AMT_W = 7;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             change_valid = 1'b0;
    logic [AMT_W-1:0] change_amt = '0;
    logic             change_ready;
    logic             empty_5 = 1'b0, empty_2 = 1'b0, empty_1 = 1'b0;
    logic             hopper_ready = 1'b1;
    logic             eject_5, eject_2, eject_1;
    logic             busy, done, short_err;
    logic [AMT_W-1:0] remaining;

    change_dispenser #(.AMT_W(AMT_W), .EJECT_GAP(2)) dut (
        .clk(clk), .reset(reset),
        .change_valid(change_valid), .change_amt(change_amt), .change_ready(change_ready),
        .empty_5(empty_5), .empty_2(empty_2), .empty_1(empty_1),
        .hopper_ready(hopper_ready),
        .eject_5(eject_5), .eject_2(eject_2), .eject_1(eject_1),
        .busy(busy), .done(done), .short_err(short_err), .remaining(remaining)
    );

    always #5 clk = ~clk;

    // kind 0 = accepted eject, kind 1 = done pulse; gap -1 means don't care
    typedef struct {
        int kind;
        int coin;
        int rem;
        int gap;
        int hold;
        int err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void push_ej(int coin, int rem, int gap, int hold);
        exp_t e;
        e.kind = 0; e.coin = coin; e.rem = rem; e.gap = gap; e.hold = hold; e.err = 0;
        q.push_back(e);
    endfunction

    function automatic void push_done(int err, int rem);
        exp_t e;
        e.kind = 1; e.coin = 0; e.rem = rem; e.gap = -1; e.hold = 0; e.err = err;
        q.push_back(e);
    endfunction

    // Monitor: outputs sampled on the falling edge; inputs change after rising edges.
    initial begin
        int hold = 0;
        int low = 0;
        logic [2:0] ej;
        int coin;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 0;
                low = 0;
                continue;
            end
            ej = {eject_5, eject_2, eject_1};
            if (ej != 3'b000) begin
                hold++;
                if (hopper_ready) begin
                    coin = (ej == 3'b100) ? 5 : (ej == 3'b010) ? 2 : (ej == 3'b001) ? 1 : -1;
                    if (q.size() == 0) chk("unexpected_eject", coin, 0);
                    else begin
                        e = q.pop_front();
                        chk("event_kind", 0, e.kind);
                        chk("eject_coin", coin, e.coin);
                        chk("eject_rem", int'(remaining), e.rem);
                        chk("eject_hold", hold, e.hold);
                        if (e.gap >= 0) chk("eject_gap", low, e.gap);
                    end
                    hold = 0;
                    low = 0;
                end
            end else low++;
            if (done) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("event_kind", 1, e.kind);
                    chk("done_short_err", int'(short_err), e.err);
                    chk("done_rem", int'(remaining), e.rem);
                end
            end
        end
    end

    task automatic send(input int amt);
        int n = 0;
        change_amt = AMT_W'(amt);
        change_valid = 1'b1;
        while (!change_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_send", int'(change_ready), 1);
        @(posedge clk); #1;
        change_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("finish_timeout", n < 200 ? 0 : 1, 0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", int'(change_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short_err), 0);
        chk("rst_ejects", int'({eject_5, eject_2, eject_1}), 0);
        chk("rst_remaining", int'(remaining), 0);

        // 8 = 5 + 2 + 1, three low cycles (2 gap + 1 select) between ejects
        push_ej(5, 8, -1, 1); push_ej(2, 3, 3, 1); push_ej(1, 1, 3, 1); push_done(0, 0);
        send(8);
        chk("busy_ready_low", int'(change_ready), 0);
        chk("busy_high", int'(busy), 1);
        wait_idle();

        // 3 with no 2-rupee coins: three 1-rupee ejects
        empty_2 = 1'b1;
        push_ej(1, 3, -1, 1); push_ej(1, 2, 3, 1); push_ej(1, 1, 3, 1); push_done(0, 0);
        send(3);
        wait_idle();
        empty_2 = 1'b0;

        // 6 with no 1-rupee coins: greedy pays 5, then shortfall of 1
        empty_1 = 1'b1;
        push_ej(5, 6, -1, 1); push_done(1, 1);
        send(6);
        wait_idle();
        empty_1 = 1'b0;

        // Backpressure: hopper not ready for the first 4 eject cycles
        hopper_ready = 1'b0;
        push_ej(5, 5, -1, 5); push_done(0, 0);
        send(5);
        n = 0;
        while (!eject_5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_eject_seen", int'(eject_5), 1);
        repeat (4) @(posedge clk);
        #1 hopper_ready = 1'b1;
        wait_idle();

        // Zero amount: done on the cycle right after the transfer
        push_done(0, 0);
        send(0);
        chk("zero_done_timing", int'(done), 1);
        chk("zero_no_eject", int'({eject_5, eject_2, eject_1}), 0);
        wait_idle();

        // Reset during a payout of 7 while the hopper stalls
        hopper_ready = 1'b0;
        send(7);
        n = 0;
        while (!eject_5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_eject_seen", int'(eject_5), 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_ejects", int'({eject_5, eject_2, eject_1}), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_remaining", int'(remaining), 0);
        reset = 1'b1;
        hopper_ready = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_ready", int'(change_ready), 1);
        chk("abort_no_done", int'(done), 0);
        repeat (3) @(posedge clk);
        #1 chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Downstream stage of the vending machine: takes the change amount owed after a sale and drives the coin hopper to pay it out.
- Pays out one coin at a time using greedy denomination selection (5, 2, 1 rupee), skipping denominations whose hopper tube is empty.
- Uses a valid/ready handshake on the input and an eject/ready handshake on the hopper.
- Reports completion and any shortfall back to the vending machine controller.

Parameters:
- AMT_W, 7, width of change amount; matches the vending machine amount bus.
- EJECT_GAP, 2, idle cycles inserted after each accepted eject (hopper settle time); legal range 0..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- change_valid  in  1  change request present.
- change_amt  in  AMT_W  rupees to return.
- change_ready  out  1  block can accept a request.
- empty_5 / empty_2 / empty_1  in  1 each  hopper tube empty flags.
- hopper_ready  in  1  hopper accepts an eject this cycle.
- eject_5 / eject_2 / eject_1  out  1 each  eject request; at most one is high at any time.
- busy  out  1  payout in progress.
- done  out  1  one-cycle pulse when the request finishes.
- short_err  out  1  one-cycle pulse, coincident with done, when change cannot be completed.
- remaining  out  AMT_W  rupees still owed; registered.

Behaviour:
- Reset (reset==0 at an edge):
  - state←IDLE; all eject_* = 0, busy 0, done 0, short_err 0, remaining 0.
  - change_ready is 1 from the first cycle after reset is released.
  - Reset mid-payout abandons the request; ejects drop at that edge and no done pulse is issued.
- States: IDLE, SELECT, EJECT, GAP, FINISH.
- IDLE:
  - change_ready=1 in IDLE only.
  - Transfer occurs when change_valid && change_ready: remaining←change_amt.
  - If change_amt==0, go to FINISH; otherwise go to SELECT.
  - busy=1 in every state except IDLE.
- SELECT (one cycle):
  - Sample empty_* and pick the largest d∈{5,2,1} with remaining≥d and !empty_d.
  - Latch the choice and go to EJECT.
  - If no denomination qualifies: set the error flag and go to FINISH.
- EJECT:
  - eject_d is registered high on entry and held until a cycle with hopper_ready==1.
  - On that accepting edge:
    - remaining←remaining−d; eject_d drops.
    - If the new remaining==0, go to FINISH.
    - Else if EJECT_GAP>0, go to GAP.
    - Else go to SELECT.
  - Changes on empty_* during EJECT are ignored; the latched choice stands.
- GAP: count EJECT_GAP cycles, then go to SELECT.
- FINISH (one cycle):
  - done=1; short_err=error flag; remaining holds the unpaid amount (0 on success).
  - Next state is IDLE and the error flag is cleared.
- Greedy selection only; no backtracking. Example: 6 with empty_1 pays 5 and then reports a shortfall of 1, even though 2+2+2 would have worked.
- Arithmetic:
  - remaining never underflows, because d≤remaining is checked in SELECT.
  - Subtraction is AMT_W bits wide.
- change_valid while busy: not accepted (change_ready=0); the requester must hold.

Decomposition:
- vm_pkg holds:
  - state enum (IDLE, SELECT, EJECT, GAP, FINISH);
  - coin value constants COIN_5=5, COIN_2=2, COIN_1=1;
  - a coin_sel_t one-hot typedef.
- Single module; the gap counter is inline, and no sub-module is warranted.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release -> change_ready=1, all outputs 0, remaining=0.
- Amount 8, EJECT_GAP=2, hopper_ready=1, no empties:
  - ejects occur in the order 5, 2, 1;
  - remaining steps 8→3→1→0;
  - done pulses once with short_err=0;
  - cycle gaps between ejects are exactly 2 idle + 1 SELECT.
- Amount 3, empty_2=1 -> three eject_1 pulses, done, short_err=0.
- Amount 6, empty_1=1 -> eject_5, then SELECT fails -> done=1, short_err=1, remaining=1.
- Backpressure: amount 5, hopper_ready low for 4 cycles -> eject_5 held high for 5 cycles, accepted on the 5th, remaining→0.
- Amount 0 -> done on the cycle after the transfer, no eject; reset=0 during a payout of 7 -> ejects drop, no done, IDLE next.
